// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART sender among N_REQ byte producers
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 20,
    parameter int START_CYCLES = 1,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   data,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 start,
    output logic [7:0]           message
);

    localparam int CNT_W = $clog2(FRAME_CYCLES) + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    ptr;

    logic               found;
    logic [ID_W-1:0]    idx;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    pick_next;
    logic [7:0]         pick_byte;
    logic [N_REQ-1:0]   pick_onehot;

    // Rotating priority scan: the first requester at or after ptr wins.
    always_comb begin
        found       = 1'b0;
        idx         = '0;
        pick        = '0;
        pick_next   = '0;
        pick_byte   = '0;
        pick_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick      = idx;
                pick_next = ID_W'((int'(idx) + 1) % N_REQ);
                pick_byte = data[int'(idx)*8 +: 8];
            end
        end
        if (found) begin
            pick_onehot[pick] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            start   <= 1'b1;
            busy    <= 1'b0;
            grant   <= '0;
            message <= '0;
            cur_id  <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        message <= pick_byte;
                        grant   <= pick_onehot;
                        cur_id  <= pick;
                        start   <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        ptr     <= pick_next;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(START_CYCLES - 1)) begin
                        start <= 1'b1;
                    end
                    // Slot ends here; one IDLE cycle follows before the next grant.
                    if (cnt == CNT_W'(FRAME_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a slot-age model
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int FC = 20;
    localparam int SC = 2;
    localparam int IW = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req;
    logic [8*N-1:0]  data;
    logic [N-1:0]    grant;
    logic            busy;
    logic [IW-1:0]   cur_id;
    logic            start;
    logic [7:0]      message;

    uart_tx_arbiter #(
        .N_REQ(N), .FRAME_CYCLES(FC), .START_CYCLES(SC), .ID_W(IW)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .data(data), .grant(grant),
        .busy(busy), .cur_id(cur_id), .start(start), .message(message)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: a slot is described only by its age since the grant edge (-1 = no slot).
    int          age    = -1;
    int          ptr_m  = 0;
    int          id_m   = 0;
    logic [7:0]  msg_m  = 8'h00;
    logic [N-1:0] grant_m = '0;
    int          mj;
    bit          mfound;

    always @(posedge CLK) begin
        cyc++;
        grant_m = '0;
        if (RST) begin
            age   = -1;
            ptr_m = 0;
            id_m  = 0;
            msg_m = 8'h00;
        end else if (age < 0) begin
            mfound = 1'b0;
            for (int i = 0; i < N; i++) begin
                mj = (ptr_m + i) % N;
                if (!mfound && req[mj]) begin
                    mfound      = 1'b1;
                    id_m        = mj;
                    msg_m       = data[8*mj +: 8];
                    grant_m[mj] = 1'b1;
                    ptr_m       = (mj + 1) % N;
                    age         = 0;
                end
            end
        end else begin
            age++;
            if (age == FC) age = -1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("start", 32'(start), 32'(!(age >= 0 && age < SC)));
            check("busy", 32'(busy), 32'(age >= 0));
            check("grant", 32'(grant), 32'(grant_m));
            check("message", 32'(message), 32'(msg_m));
            check("cur_id", 32'(cur_id), 32'(id_m));
        end
    end

    function automatic int onehot_id(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++) if (g == (N'(1) << i)) r = i;
        return r;
    endfunction

    // Advances at least one negedge, then waits (bounded) for a grant pulse.
    task automatic wait_grant(input string name);
        int n = 0;
        @(negedge CLK);
        while (grant == '0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (grant == '0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no grant, expected one within 60 cycles", name);
        end
    endtask

    int ids[5];
    int msgs[5];
    int tg[5];
    int exp_ids[5]  = '{0, 1, 2, 3, 0};
    int exp_msgs[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int lows, busys;

    initial begin
        RST  = 1'b1;
        req  = 4'b1111;
        data = '0;
        @(posedge CLK);
        chk_en = 1'b1;

        // Reset held with all requests active: nothing may be granted.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_start", 32'(start), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_message", 32'(message), 32'd0);
        end
        RST = 1'b0;
        req = '0;

        // Single request, then data changed during the slot.
        @(negedge CLK);
        data[7:0] = 8'h95;
        req = 4'b0001;
        wait_grant("single");
        check("single_grant", 32'(grant), 32'b0001);
        check("single_message", 32'(message), 32'h95);
        check("single_cur_id", 32'(cur_id), 32'd0);
        req = '0;
        lows = 0;
        busys = 0;
        for (int i = 0; i < 25; i++) begin
            if (!start) lows++;
            if (busy) busys++;
            if (i == 4) data[7:0] = 8'h00;
            @(negedge CLK);
        end
        check("single_start_low_cycles", 32'(lows), 32'd2);
        check("single_busy_cycles", 32'(busys), 32'd20);
        check("data_change_message", 32'(message), 32'h95);

        // Round-robin from a freshly reset pointer.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr");
            ids[k]  = onehot_id(grant);
            msgs[k] = int'(message);
            tg[k]   = cyc;
        end
        for (int k = 0; k < 5; k++) begin
            check("rr_id", 32'(ids[k]), 32'(exp_ids[k]));
            check("rr_message", 32'(msgs[k]), 32'(exp_msgs[k]));
            if (k > 0) check("rr_start_spacing", 32'(tg[k] - tg[k-1]), 32'd21);
        end

        // Pointer: after granting 1, requester 2 outranks requester 0.
        req = 4'b0010;
        wait_grant("ptr_a");
        check("ptr_first", 32'(onehot_id(grant)), 32'd1);
        req = 4'b0101;
        wait_grant("ptr_b");
        check("ptr_second", 32'(onehot_id(grant)), 32'd2);
        wait_grant("ptr_c");
        check("ptr_third", 32'(onehot_id(grant)), 32'd0);

        // Mid-frame reset at cnt=5; pointer must restart at 0.
        req = 4'b1001;
        for (int i = 0; i < 5; i++) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_start", 32'(start), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        RST = 1'b0;
        wait_grant("midrst");
        check("midrst_regrant", 32'(grant), 32'b0001);
        check("midrst_cur_id", 32'(cur_id), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            data = $urandom;
            RST  = ($urandom_range(0, 299) == 0);
        end
        RST = 1'b0;
        req = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
